// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum accumulator block.
// State encoding and sample-counter width.
package sum_accumulator_pkg;

  localparam int unsigned COUNT_W = 16;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/sample_counter.sv
// Samples-per-block counter with terminal-count flag.
// Synchronous clear has priority over increment.
module sample_counter
  import sum_accumulator_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               last_o
);

  localparam logic [COUNT_W-1:0] LAST =
    COUNT_W'(N_SAMPLES - 1);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  // next count: clear wins, else step on accept
  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (inc_i)
      count_d = count_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LAST);

endmodule

// File: rtl/sum_accumulator.sv
// Sums N_SAMPLES stream samples and offers the total on a handshake.
// ACC_SATURATE_EN: clamp the total at all-ones on overflow instead of wrapping.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int unsigned IN_W      = 5,
  parameter int unsigned ACC_W     = 9,
  parameter int unsigned N_SAMPLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_acc,
  output logic               out_ovf,
  output logic [COUNT_W-1:0] count
);

  acc_state_e state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum_w;
  logic             accept;
  logic             handoff;
  logic             last;

  assign sum_w = {1'b0, acc_q} + (ACC_W+1)'(in_sum);

  // next state, accumulate/overflow datapath and handshake outputs
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    handoff   = 1'b0;
    unique case (state_q)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (sum_w[ACC_W])
            ovf_d = 1'b1;
`ifdef ACC_SATURATE_EN
          acc_d = sum_w[ACC_W] ? {ACC_W{1'b1}}
                               : sum_w[ACC_W-1:0];
`else
          acc_d = sum_w[ACC_W-1:0];
`endif
          if (last)
            state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          handoff = 1'b1;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
    if (clr) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  // state, accumulator and sticky overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  sample_counter #(
    .N_SAMPLES (N_SAMPLES)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr | handoff),
    .inc_i   (accept),
    .count_o (count),
    .last_o  (last)
  );

  assign out_acc = acc_q;
  assign out_ovf = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomized and directed checks of sum_accumulator
// against an arithmetic model of block summation.
module tb_sum_accumulator;

  localparam int IN_W  = 5;
  localparam int ACC_W = 8;
  localparam int NS    = 16;
  localparam int MAXV  = (1 << ACC_W);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic [15:0]      count;

  int n_vec = 0;
  int n_err = 0;

  int m_acc, m_cnt;
  bit m_ovf, m_hold;

  sum_accumulator #(
    .IN_W      (IN_W),
    .ACC_W     (ACC_W),
    .N_SAMPLES (NS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc  = 0;
    m_cnt  = 0;
    m_ovf  = 0;
    m_hold = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ovalid"}, int'(out_valid), int'(m_hold));
    check({tag, ".iready"}, int'(in_ready), int'(!m_hold));
    check({tag, ".acc"}, int'(out_acc), m_acc);
    check({tag, ".ovf"}, int'(out_ovf), int'(m_ovf));
    check({tag, ".cnt"}, int'(count), m_cnt);
  endtask

  // one clock: drive, advance model, check #1 after the edge
  task automatic cyc(input bit v, input int s,
                     input bit r, input bit c,
                     input string tag);
    int sum;
    in_valid  = v;
    in_sum    = IN_W'(s);
    out_ready = r;
    clr       = c;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else if (!m_hold && v) begin
      sum = m_acc + s;
      if (sum >= MAXV) begin
        m_ovf = 1;
`ifdef ACC_SATURATE_EN
        sum = MAXV - 1;
`else
        sum = sum - MAXV;
`endif
      end
      m_acc = sum;
      m_cnt++;
      if (m_cnt == NS) m_hold = 1;
    end else if (m_hold && r) begin
      m_acc  = 0;
      m_cnt  = 0;
      m_ovf  = 0;
      m_hold = 0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic async_rst(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    async_rst("rst0");

    for (int i = 0; i < NS; i++) cyc(1, 5, 0, 0, "five");
    check("acc80", int'(out_acc), 80);
    check("hold_valid", int'(out_valid), 1);

    for (int i = 0; i < 5; i++) cyc(1, 7, 0, 0, "bp");
    check("bp_acc", int'(out_acc), 80);
    check("bp_cnt", int'(count), 16);
    cyc(1, 7, 1, 0, "handoff");
    check("ho_cnt", int'(count), 0);
    check("ho_rdy", int'(in_ready), 1);

    for (int i = 0; i < NS; i++) begin
      cyc(1, i, 0, 0, "gap_v");
      if (i < NS - 1) cyc(0, 31, 0, 0, "gap_n");
    end
    check("acc120", int'(out_acc), 120);
    cyc(0, 0, 1, 0, "gap_ho");

    for (int i = 0; i < NS; i++) cyc(1, 31, 0, 0, "ovf");
`ifdef ACC_SATURATE_EN
    check("ovf_acc", int'(out_acc), 255);
`else
    check("ovf_acc", int'(out_acc), 240);
`endif
    check("ovf_flag", int'(out_ovf), 1);
    cyc(0, 0, 1, 0, "ovf_ho");
    for (int i = 0; i < NS; i++) cyc(1, 1, 0, 0, "ones");
    check("ones_acc", int'(out_acc), 16);
    check("ones_ovf", int'(out_ovf), 0);
    cyc(0, 0, 1, 0, "ones_ho");

    for (int i = 0; i < 7; i++) cyc(1, 3, 0, 0, "pre_rst");
    async_rst("mid_rst");
    for (int i = 0; i < NS; i++) cyc(1, 1, 0, 0, "post_rst");
    check("rst_acc", int'(out_acc), 16);
    cyc(0, 0, 1, 0, "rst_ho");

    for (int i = 0; i < 7; i++) cyc(1, 3, 0, 0, "pre_clr");
    cyc(1, 3, 0, 1, "clr");
    for (int i = 0; i < NS; i++) cyc(1, 1, 0, 0, "post_clr");
    check("clr_acc", int'(out_acc), 16);
    cyc(1, 9, 0, 1, "clr_hold");

    for (int i = 0; i < 600; i++)
      cyc($urandom_range(3, 0) != 0,
          int'($urandom_range(31, 0)),
          $urandom_range(1, 0) == 1,
          $urandom_range(49, 0) == 0,
          "rand");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream stage of the 4-bit adder: consumes its 5-bit sum `s` as a stream of samples.
- Adds N_SAMPLES accepted samples into a wider accumulator, then presents the total on a valid/ready output handshake.
- Used for multi-operand summation and as a self-checking consumer in adder benches.

Parameters:
- IN_W, 5, width of incoming sum (adder output width).
- ACC_W, 9, accumulator/output width; default holds 16*31=496 without overflow.
- N_SAMPLES, 16, number of samples per result; legal range 1..2^16-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear; abandons the current block.
- in_valid  in  1  in_sum is valid this cycle.
- in_ready  out  1  block can accept a sample this cycle.
- in_sum  in  IN_W  sample (adder `s`), unsigned.
- out_valid  out  1  out_acc/out_ovf hold a completed result.
- out_ready  in  1  consumer takes the result.
- out_acc  out  ACC_W  accumulated total.
- out_ovf  out  1  sticky overflow of the current block.
- count  out  16  samples accepted in the current block.

Behaviour:
- Reset (async assert, sync release): state=ACCUM; acc=0, count=0, out_ovf=0, out_valid=0, in_ready=1.
- Priority at each clock edge: rst > clr > handshakes.
- clr: same values as reset, applied at the clock edge; valid in either state, drops any pending result.
- FSM ACCUM:
  - in_ready=1, out_valid=0.
  - Accept when in_valid&in_ready: acc<=acc+in_sum (zero-extended; sum formed in ACC_W+1 bits), count<=count+1.
  - If count==N_SAMPLES-1 at accept: go to HOLD.
- FSM HOLD:
  - in_ready=0, out_valid=1.
  - out_acc and out_ovf stable until handshake; in_valid ignored, no sample lost or double-counted.
  - On out_valid&out_ready: acc=0, count=0, ovf=0, go to ACCUM; in_ready=1 next cycle.
- Latency: out_valid rises the cycle after the Nth accept.
- out_acc mirrors acc in both states, so the partial sum is visible during ACCUM.
- Minimum period per block is N_SAMPLES+1 cycles; there is no accept in the handoff cycle.
- Overflow: carry out of bit ACC_W-1 at any accept sets out_ovf; out_ovf stays set until handshake/clr/rst.
- N_SAMPLES=1: every accept goes straight to HOLD.
- count never exceeds N_SAMPLES.
- rst mid-block: partial sum discarded immediately, without waiting for a clock edge.

Optional Feature:
- Macro ACC_SATURATE_EN.
- Defined: on overflow, acc clamps to 2^ACC_W-1 and stays there for the rest of the block; out_ovf is still set.
- Undefined: acc wraps modulo 2^ACC_W.

Decomposition:
- Shared include sum_accumulator_defs.vh holds:
  - state encodings ST_ACCUM=1'b0, ST_HOLD=1'b1;
  - COUNT_W=16.
- One natural sub-module: sample_counter (count register, terminal-count flag `last`, sync clear), instantiated once.
- Accumulate/overflow/saturate datapath stays inline.

Test Plan:
- Reset: pulse rst between clock edges -> immediately out_valid=0, in_ready=1, out_acc=0, out_ovf=0, count=0.
- 16 back-to-back samples of 5 -> out_valid=1 the cycle after the 16th accept; out_acc=80, out_ovf=0, in_ready=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_acc stays 80, count stays 16, no accept; then out_ready=1 -> next cycle count=0, in_ready=1.
- Gapped input: values 0..15 with in_valid every other cycle -> out_acc=120 after the 16th accept, no extra samples counted.
- Overflow (ACC_W=8), 16 samples of 31:
  - without ACC_SATURATE_EN: out_acc=240, out_ovf=1;
  - with ACC_SATURATE_EN: out_acc=255, out_ovf=1;
  - next block of 16 ones -> out_acc=16, out_ovf=0.
- rst or clr mid-block: after 7 samples of 3, assert rst asynchronously (repeat the run with clr) -> acc=0, count=0; then 16 samples of 1 -> out_acc=16.
